wb_stage: RTL

- Write-back stage for the 8-bit RISC pipeline; the producer end of the register-file write interface that the decode stage consumes.
- Accepts completed results from execute (ALU results and load requests) into a small pending-write buffer.
- Waits for data-memory responses on loads, then drives the register-file write address, write enable and write-data mux select.
- Flags read-after-write hazards against the decode stage's source addresses.

---
 rtl/riscpkg.sv | 32 +++
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscpkg.sv
// ---------------------------------------------------------------------------
// riscpkg -- shared definitions for the 8-bit RISC write-back path.
//
// Contents:
//   DW, AW       data width and register address width
//   wb_state_e   write-back FSM state encoding (IDLE = 0, WAIT_MEM = 1)
//   wb_entry_t   pending-write buffer entry {dest, data, is_load}
//   LD_ERR_DATA  value written to the register file when a load times out
// ---------------------------------------------------------------------------
package riscpkg;

  localparam int DW = 8;
  localparam int AW = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam int ENTRY_DEST_W = AW;
  localparam int ENTRY_DATA_W = DW;
  localparam int ENTRY_W      = ENTRY_DEST_W + ENTRY_DATA_W + 1;

  typedef struct packed {
    logic [ENTRY_DEST_W-1:0] dest;
    logic [ENTRY_DATA_W-1:0] data;
    logic                    is_load;
  } wb_entry_t;

  localparam logic [DW-1:0] LD_ERR_DATA = 8'hFF;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo -- circular pending-write buffer for the write-back stage.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push_i           write push_entry_i at the tail (ignored when full)
//   push_entry_i     entry to append
//   pop_i            drop the head entry (ignored when empty)
//   full_o, empty_o  occupancy flags
//   head_o           oldest entry (valid only when !empty_o)
//   ent_valid_o      per-entry valid, in age order (index 0 = head)
//   ent_dest_o       per-entry destination, in age order
//   ent_is_load_o    per-entry load flag, in age order
//   ent_data_o       per-entry ALU data, in age order
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
  import riscpkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_entry_t                    head_o,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0]     ent_dest_o,
  output logic [DEPTH-1:0]             ent_is_load_o,
  output logic [DEPTH-1:0][DW-1:0]     ent_data_o
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW:0] cnt_t;

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  cnt_t            count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign empty_o = (count_q == '0);

  // Acceptance uses only the registered occupancy: a pop in the same cycle
  // does not open a slot for a push while full.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o = mem_q[rd_ptr_q];

  // Present every slot in age order so consumers can pick the youngest match
  // without knowing the pointer position.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] slot;
    assign slot              = rd_ptr_q + PW'(gi);
    assign ent_valid_o[gi]   = (cnt_t'(gi) < count_q);
    assign ent_dest_o[gi]    = mem_q[slot].dest;
    assign ent_is_load_o[gi] = mem_q[slot].is_load;
    assign ent_data_o[gi]    = mem_q[slot].data;
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back stage of the 8-bit RISC pipeline.
//
// Buffers completed execute results, waits for memory data on loads and
// drives the register-file write port. Flags read-after-write hazards
// against the decode stage's source registers.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   res_valid/res_ready      execute result handshake (ready = buffer not full)
//   res_dest/res_data        destination register and ALU result
//   res_is_load              result is a load; data arrives on mem_rdata
//   mem_rvalid/mem_rdata     one-cycle load data pulse
//   rd_addr_a/rd_addr_b      decode source addresses
//   regaddrc                 {write dest or rd_addr_a, rd_addr_b}
//   RegCR                    register-file write enable
//   wb_in / wb_AorD          write mux inputs 0 (ALU) / 1 (load)
//   mux2CR                   write mux select
//   hazard                   decode must stall
//   ld_err                   sticky load-timeout flag
//
// Optional build macro WB_BYPASS_EN adds fwd_a_valid/fwd_b_valid and
// fwd_a_data/fwd_b_data, forwarding the youngest matching ALU result; hazard
// then asserts only when that youngest match is a load.
// ---------------------------------------------------------------------------
module wb_stage
  import riscpkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [AW-1:0]   res_dest,
  input  logic [DW-1:0]   res_data,
  input  logic            res_is_load,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [2*AW-1:0] regaddrc,
  output logic            RegCR,
  output logic [DW-1:0]   wb_in,
  output logic [DW-1:0]   wb_AorD,
  output logic            mux2CR,
  output logic            hazard,
`ifdef WB_BYPASS_EN
  output logic            fwd_a_valid,
  output logic            fwd_b_valid,
  output logic [DW-1:0]   fwd_a_data,
  output logic [DW-1:0]   fwd_b_data,
`endif
  output logic            ld_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // -------------------------------------------------------------------------
  // Pending-write buffer
  // -------------------------------------------------------------------------
  wb_entry_t                 push_entry;
  wb_entry_t                 head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0][AW-1:0]  ent_dest;
  logic [DEPTH-1:0]          ent_is_load;
  logic [DEPTH-1:0][DW-1:0]  ent_data;

  assign push_entry = '{dest: res_dest, data: res_data, is_load: res_is_load};
  assign res_ready  = !fifo_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (res_valid),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_o        (head),
    .ent_valid_o   (ent_valid),
    .ent_dest_o    (ent_dest),
    .ent_is_load_o (ent_is_load),
    .ent_data_o    (ent_data)
  );

  // -------------------------------------------------------------------------
  // Write-back FSM
  // -------------------------------------------------------------------------
  wb_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             sel_q, sel_d;
  logic             err_q, err_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic [DW-1:0]    alu_q, alu_d;
  logic [DW-1:0]    ld_q, ld_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    err_d   = err_q;
    dest_d  = dest_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head.is_load) begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end else begin
            we_d   = 1'b1;
            sel_d  = 1'b0;
            alu_d  = head.data;
            dest_d = head.dest;
            pop    = 1'b1;
          end
        end
      end

      WAIT_MEM: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          we_d    = 1'b1;
          sel_d   = 1'b1;
          ld_d    = mem_rdata;
          dest_d  = head.dest;
          pop     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Counter reaches TIMEOUT on this edge: give up and write the
          // error marker so the destination register is not left stale.
          we_d    = 1'b1;
          sel_d   = 1'b1;
          ld_d    = LD_ERR_DATA;
          dest_d  = head.dest;
          err_d   = 1'b1;
          pop     = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      dest_q  <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      dest_q  <= dest_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
    end
  end

  assign RegCR    = we_q;
  assign mux2CR   = sel_q;
  assign wb_in    = alu_q;
  assign wb_AorD  = ld_q;
  assign ld_err   = err_q;
  // The upper address field is shared between the write port and read port A.
  assign regaddrc = {(we_q ? dest_q : rd_addr_a), rd_addr_b};

  // -------------------------------------------------------------------------
  // Hazard detection (and optional forwarding), one slice per source port
  // -------------------------------------------------------------------------
  logic [1:0][AW-1:0] src_addr;
  logic [1:0]         port_haz;

  assign src_addr = {rd_addr_b, rd_addr_a};

`ifdef WB_BYPASS_EN
  logic [1:0]          fwd_valid;
  logic [1:0][DW-1:0]  fwd_data;
`endif

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    logic [DEPTH-1:0] hit;
    logic             inflight_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign hit[gi] = ent_valid[gi] && (ent_dest[gi] == src_addr[gp]);
    end

    assign inflight_hit = we_q && (dest_q == src_addr[gp]);

`ifdef WB_BYPASS_EN
    logic            match;
    logic            match_load;
    logic [DW-1:0]   match_data;

    // The in-flight write is older than every buffered entry; scanning the
    // buffer head-to-tail lets the youngest match overwrite older ones.
    // An in-flight load write is treated as a load (no forwarding).
    always_comb begin
      match      = inflight_hit;
      match_load = sel_q;
      match_data = alu_q;
      for (int i = 0; i < DEPTH; i++) begin
        if (hit[i]) begin
          match      = 1'b1;
          match_load = ent_is_load[i];
          match_data = ent_data[i];
        end
      end
    end

    assign port_haz[gp]  = match && match_load;
    assign fwd_valid[gp] = match && !match_load;
    assign fwd_data[gp]  = (match && !match_load) ? match_data : '0;
`else
    assign port_haz[gp] = inflight_hit || (|hit);
`endif
  end

  assign hazard = |port_haz;

`ifdef WB_BYPASS_EN
  assign fwd_a_valid = fwd_valid[0];
  assign fwd_b_valid = fwd_valid[1];
  assign fwd_a_data  = fwd_data[0];
  assign fwd_b_data  = fwd_data[1];
`else
  // Entry payload is only needed for forwarding.
  logic unused_fifo_payload;
  assign unused_fifo_payload = ^{ent_is_load, ent_data};
`endif

endmodule
